// File: rtl/canxl_fcrc_field.sv
// CAN XL FCRC field stage: latches the frame CRC, then serializes (TX)
// or checks (RX) it with fixed stuff bits inserted every STUFF_PERIOD bits.
module canxl_fcrc_field #(
    parameter int FCRC_LEN     = 32,
    parameter int STUFF_PERIOD = 10
) (
    input  logic        clk,
    input  logic        g_rst,
    input  logic        bit_tick,
    input  logic        start,
    input  logic        tx_mode,
    input  logic        abort,
    input  logic [31:0] fcrc_frm,
    input  logic        rx_bit,
    output logic        tx_bit,
    output logic        busy,
    output logic        fcrc_done,
    output logic        crc_err,
    output logic        stuff_err
);
    localparam int BW = $clog2(FCRC_LEN + 1);
    localparam int GW = $clog2(STUFF_PERIOD + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FCRC_LEN - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(STUFF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DATA, STUFF, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;
    logic          mode_q, mode_d;
    logic          rx_cmp_q, rx_cmp_d;
    logic          last_q, last_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          crc_q, crc_d;
    logic          serr_q, serr_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        grp_cnt_d = grp_cnt_q;
        mode_d    = mode_q;
        rx_cmp_d  = rx_cmp_q;
        last_d    = last_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crc_d     = crc_q;
        serr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    shift_d   = fcrc_frm;
                    mode_d    = tx_mode;
                    bit_cnt_d = '0;
                    grp_cnt_d = '0;
                    rx_cmp_d  = 1'b0;
                    crc_d     = 1'b0;
                    tx_d      = fcrc_frm[31];
                    busy_d    = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: if (bit_tick) begin
                last_d    = shift_q[31];
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + BW'(1);
                grp_cnt_d = grp_cnt_q + GW'(1);
                if (!mode_q)
                    rx_cmp_d = rx_cmp_q | (rx_bit ^ shift_q[31]);
                // no stuff bit after the last data bit, even on a group boundary
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    crc_d   = ~mode_q & rx_cmp_d;
                end else if (grp_cnt_q == GRP_LAST) begin
                    grp_cnt_d = '0;
                    tx_d      = ~shift_q[31];
                    state_d   = STUFF;
                end else begin
                    tx_d = shift_q[30];
                end
            end
            STUFF: if (bit_tick) begin
                if (!mode_q && rx_bit == last_q)
                    serr_d = 1'b1;
                tx_d    = shift_q[31];
                state_d = DATA;
            end
            DONE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            crc_d   = 1'b0;
            serr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            grp_cnt_q <= '0;
            mode_q    <= 1'b0;
            rx_cmp_q  <= 1'b0;
            last_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_q     <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            grp_cnt_q <= grp_cnt_d;
            mode_q    <= mode_d;
            rx_cmp_q  <= rx_cmp_d;
            last_q    <= last_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crc_q     <= crc_d;
            serr_q    <= serr_d;
        end
    end

    assign tx_bit    = tx_q;
    assign busy      = busy_q;
    assign fcrc_done = done_q;
    assign crc_err   = crc_q;
    assign stuff_err = serr_q;
endmodule

// File: tb/tb_canxl_fcrc_field.sv
// Directed bench for canxl_fcrc_field: TX serialization, RX CRC and
// stuff checking, abort, reset and start-while-busy behaviour.
module tb_canxl_fcrc_field;
    logic        clk = 1'b0;
    logic        g_rst = 1'b1;
    logic        bit_tick = 1'b0;
    logic        start = 1'b0;
    logic        tx_mode = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] fcrc_frm = '0;
    logic        rx_bit = 1'b1;
    logic        tx_bit, busy, fcrc_done, crc_err, stuff_err;

    int checks = 0;
    int failures = 0;

    logic s_err, s_done, s_crc;
    logic [34:0] seq;
    logic [34:0] seq1;

    canxl_fcrc_field dut (
        .clk(clk), .g_rst(g_rst), .bit_tick(bit_tick), .start(start),
        .tx_mode(tx_mode), .abort(abort), .fcrc_frm(fcrc_frm),
        .rx_bit(rx_bit), .tx_bit(tx_bit), .busy(busy),
        .fcrc_done(fcrc_done), .crc_err(crc_err), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [31:0] frm, input logic mode);
        @(negedge clk);
        start = 1'b1; fcrc_frm = frm; tx_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // one bit time: tick on one clk, then 3 idle clks
    task automatic do_tick(input logic rb);
        @(negedge clk);
        bit_tick = 1'b1; rx_bit = rb;
        @(posedge clk); #1;
        bit_tick = 1'b0;
        s_err = stuff_err; s_done = fcrc_done; s_crc = crc_err;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        g_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_bit, busy, fcrc_done, crc_err, stuff_err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=10000",
                     {tx_bit, busy, fcrc_done, crc_err, stuff_err});
        end
        g_rst = 1'b0;
    endtask

    task automatic test_tx;
        logic [34:0] got;
        int bad_busy = 0, early_done = 0;
        do_start(32'hFA567D89, 1'b1);
        fcrc_frm = 32'h0;
        for (int i = 0; i < 35; i++) begin
            got[34-i] = tx_bit;
            if (!busy) bad_busy++;
            do_tick(1'b1);
            if (i < 34 && s_done) early_done++;
        end
        checks++;
        if (got !== seq) begin
            failures++;
            $display("FAIL tx_seq got=%b want=%b", got, seq);
        end
        checks++;
        if (bad_busy != 0 || early_done != 0) begin
            failures++;
            $display("FAIL tx_busy_window busy_low=%0d early_done=%0d want=0,0",
                     bad_busy, early_done);
        end
        checks++;
        if ({s_done, s_crc} !== 2'b10) begin
            failures++;
            $display("FAIL tx_done got=%b want=10", {s_done, s_crc});
        end
        checks++;
        if ({tx_bit, busy, fcrc_done} !== 3'b100) begin
            failures++;
            $display("FAIL tx_after got=%b want=100", {tx_bit, busy, fcrc_done});
        end
    endtask

    task automatic test_rx(input int flip, input logic exp_crc, input int serr_pos,
                           input string name);
        logic [34:0] rx;
        int nerr = 0, wrong_pos = 0;
        rx = seq;
        if (flip >= 0) rx[34-flip] = ~rx[34-flip];
        do_start(32'hFA567D89, 1'b0);
        for (int i = 0; i < 35; i++) begin
            do_tick(rx[34-i]);
            if (s_err) begin
                nerr++;
                if (i != serr_pos) wrong_pos++;
            end
        end
        checks++;
        if ({s_done, s_crc} !== {1'b1, exp_crc}) begin
            failures++;
            $display("FAIL %s_done_crc got=%b want=%b", name, {s_done, s_crc},
                     {1'b1, exp_crc});
        end
        checks++;
        if (nerr != (serr_pos >= 0 ? 1 : 0) || wrong_pos != 0) begin
            failures++;
            $display("FAIL %s_stuff_err pulses=%0d wrong_pos=%0d want=%0d,0",
                     name, nerr, wrong_pos, serr_pos >= 0 ? 1 : 0);
        end
        checks++;
        if (crc_err !== exp_crc || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold got=%b want=%b0", name, {crc_err, busy}, exp_crc);
        end
    endtask

    task automatic test_abort;
        logic [34:0] got;
        int dn = 0;
        do_start(32'hFA567D89, 1'b1);
        for (int i = 0; i < 11; i++) do_tick(1'b1);
        @(negedge clk);
        bit_tick = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0; abort = 1'b0;
        checks++;
        if ({tx_bit, busy, fcrc_done} !== 3'b100) begin
            failures++;
            $display("FAIL abort_state got=%b want=100", {tx_bit, busy, fcrc_done});
        end
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b1);
            if (s_done || busy) dn++;
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL abort_idle active_ticks=%0d want=0", dn);
        end
        do_start(32'h00000001, 1'b1);
        for (int i = 0; i < 35; i++) begin
            got[34-i] = tx_bit;
            do_tick(1'b1);
        end
        checks++;
        if (got !== seq1) begin
            failures++;
            $display("FAIL abort_restart_seq got=%b want=%b", got, seq1);
        end
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_done got=%b want=1", s_done);
        end
    endtask

    task automatic test_busy_start_reset;
        logic [19:0] got;
        do_start(32'hFA567D89, 1'b1);
        for (int i = 0; i < 20; i++) begin
            got[19-i] = tx_bit;
            if (i == 5) begin
                do_start(32'h00000000, 1'b0);
                do_tick(1'b1);
            end else begin
                do_tick(1'b1);
            end
        end
        checks++;
        if (got !== seq[34:15]) begin
            failures++;
            $display("FAIL busy_start_seq got=%b want=%b", got, seq[34:15]);
        end
        @(negedge clk);
        g_rst = 1'b1; bit_tick = 1'b1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        g_rst = 1'b0; bit_tick = 1'b0; start = 1'b0; abort = 1'b0;
        checks++;
        if ({tx_bit, busy, fcrc_done, crc_err, stuff_err} !== 5'b10000) begin
            failures++;
            $display("FAIL mid_reset got=%b want=10000",
                     {tx_bit, busy, fcrc_done, crc_err, stuff_err});
        end
        do_tick(1'b1);
        checks++;
        if ({tx_bit, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_stays_idle got=%b want=10", {tx_bit, busy});
        end
    endtask

    initial begin
        seq  = {10'b1111101001, 1'b0, 10'b0101100111, 1'b0,
                10'b1101100010, 1'b1, 2'b01};
        seq1 = {10'b0000000000, 1'b1, 10'b0000000000, 1'b1,
                10'b0000000000, 1'b1, 2'b01};
        test_reset;
        test_tx;
        test_rx(-1, 1'b0, -1, "rx_ok");
        test_rx(17, 1'b1, -1, "rx_crc");
        test_rx(21, 1'b0, 21, "rx_stuff");
        test_abort;
        test_busy_start_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/canxl_fcrc_field.md
Name: canxl_fcrc_field

Overview:
- Downstream stage of the CAN XL frame-CRC generator.
- At the end of the data field it latches the 32-bit FCRC register value (fcrc_frm), then handles the FCRC field itself:
  - TX: serializes the latched FCRC MSB-first.
  - RX: compares the received FCRC bits against the latched value.
- In both directions it inserts (TX) or checks (RX) fixed stuff bits.
- Reports completion, CRC mismatch and fixed-stuff errors to the frame controller.

Parameters:
- FCRC_LEN, 32, number of FCRC bits in the field.
- STUFF_PERIOD, 10, data bits between consecutive fixed stuff bits.

Ports:
- clk  input  1  system clock.
- g_rst  input  1  synchronous, active-high reset.
- bit_tick  input  1  one-cycle strobe per CAN bit time (sample point).
- start  input  1  end of data field; latch fcrc_frm and begin the field.
- tx_mode  input  1  1 = transmitter, 0 = receiver; sampled with start.
- abort  input  1  error/bus-off from the frame controller; return to idle.
- fcrc_frm  input  32  running frame CRC from the FCRC generator.
- rx_bit  input  1  received bus bit, valid when bit_tick = 1.
- tx_bit  output  1  bit to drive on the bus (1 = recessive).
- busy  output  1  field in progress.
- fcrc_done  output  1  one-cycle pulse at the end of the field.
- crc_err  output  1  RX only: received FCRC differs from latched value; valid with fcrc_done.
- stuff_err  output  1  RX only: a fixed stuff bit was not the inverse of the preceding bit; one-cycle pulse.

Behaviour:
- Reset (g_rst = 1 at a clk edge): state IDLE, tx_bit = 1, busy = 0, fcrc_done = 0, crc_err = 0, stuff_err = 0, counters = 0, shift register = 0. g_rst overrides every other input.
- Priority: g_rst > abort > start > bit_tick.
- States: IDLE, DATA, STUFF, DONE.
- IDLE:
  - tx_bit = 1.
  - start = 1 → shift register ← fcrc_frm, mode ← tx_mode, bit_cnt ← 0, grp_cnt ← 0, rx_cmp ← 0, tx_bit ← fcrc_frm[31], busy ← 1, state DATA.
  - Capture is in the same cycle as start; start and bit_tick together use the capture only, with no bit consumed.
- DATA, on bit_tick, the current bit is consumed:
  - TX: tx_bit was on the bus for this bit.
  - RX: rx_bit is sampled; rx_cmp ← rx_cmp | (rx_bit ^ shift[31]).
  - last_bit ← current data bit; shift ← shift << 1; bit_cnt += 1; grp_cnt += 1.
  - If bit_cnt was FCRC_LEN-1 → DONE. A final stuff bit is never inserted after the last data bit, even when it completes a group.
  - Else if grp_cnt was STUFF_PERIOD-1 → grp_cnt ← 0, tx_bit ← ~last_bit, state STUFF.
  - Else tx_bit ← next data bit.
- STUFF, on bit_tick:
  - RX: if rx_bit != ~last_bit, pulse stuff_err for one cycle and continue; the frame controller decides whether to abort.
  - tx_bit ← next data bit; state DATA.
- DONE (one cycle):
  - fcrc_done = 1; crc_err = rx_cmp when mode = RX, 0 when mode = TX.
  - tx_bit ← 1, busy ← 0, state IDLE.
  - crc_err is held until the next start or reset.
- Without bit_tick, all state holds. tx_bit is registered and changes only on bit_tick, start, DONE exit, abort or reset.
- Field length with defaults: 32 data bits + 3 stuff bits (after data bits 10, 20, 30) = 35 bit_ticks. fcrc_done is asserted in the cycle after the 35th tick.
- start while busy: ignored.
- abort in any state: → IDLE, tx_bit = 1, busy = 0, no fcrc_done, error flags cleared.
- fcrc_frm changes after capture have no effect.

Test Plan:
- TX, fcrc_frm = 32'hFA567D89, start then 35 ticks spaced 4 clk apart:
  - tx_bit sequence: 1111101001 0 0101100111 0 1101100010 1 01.
  - fcrc_done one cycle after tick 35; crc_err = 0; busy high from start until done.
- RX, fcrc_frm = 32'hFA567D89, rx_bit driven with the same 35-bit sequence → fcrc_done with crc_err = 0, no stuff_err.
- RX, same setup but data bit 17 flipped → crc_err = 1 at fcrc_done, stuff_err never asserted.
- RX, second stuff bit (stream position 22) sent as 1 → stuff_err pulse at that tick, field completes, crc_err = 0.
- abort asserted at tick 12 in TX → tx_bit = 1 and busy = 0 next cycle, no fcrc_done. A new start with fcrc_frm = 32'h00000001 then produces stuff bits 1, 1, 1 and last data bits 01.
- g_rst asserted mid-field, and start asserted while busy → reset returns all outputs to reset values on the next edge; the busy-time start is ignored, with the bit sequence unchanged.
